// File: rtl/split_thread_scheduler.sv
// Job sequencer: cuts a byte region into CHUNK-sized pieces and hands them round-robin to worker threads.
// Build option: define SPLIT_SCHED_PERF_CNT_EN to report per-job latency on cycle_count.
module split_thread_scheduler #(
    parameter int NUM_THREADS = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 16,
    parameter int CHUNK       = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [LEN_W-1:0]       total_len,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_THREADS-1:0] thr_start,
    output logic [ADDR_W-1:0]      thr_addr,
    output logic [LEN_W-1:0]       thr_len,
    input  logic [NUM_THREADS-1:0] thr_done,
    output logic [31:0]            cycle_count
);
    localparam int PTR_W = $clog2(NUM_THREADS);
    localparam logic [LEN_W-1:0] CHUNK_L = LEN_W'(CHUNK);

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_DONE} state_t;

    state_t                 state_reg;
    logic [ADDR_W-1:0]      cur_addr_reg;
    logic [LEN_W-1:0]       remaining_reg;
    logic [NUM_THREADS-1:0] busy_mask_reg;
    logic [PTR_W-1:0]       ptr_reg;

    logic [NUM_THREADS-1:0] free_vec;
    logic [NUM_THREADS-1:0] ge_ptr;
    logic [NUM_THREADS-1:0] hi_vec;
    logic [NUM_THREADS-1:0] pick_vec;
    logic [NUM_THREADS-1:0] grant_oh;
    logic [PTR_W-1:0]       idx_part [NUM_THREADS];
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       ptr_next;
    logic                   grant_any;
    logic [LEN_W-1:0]       chunk_len;

    // Rotating priority: prefer free threads at or above the pointer, else wrap to the lowest free one.
    assign free_vec = ~busy_mask_reg;

    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_ge
        assign ge_ptr[gi] = (PTR_W'(gi) >= ptr_reg);
    end

    assign hi_vec   = free_vec & ge_ptr;
    assign pick_vec = (|hi_vec) ? hi_vec : free_vec;
    assign grant_oh = pick_vec & ~(pick_vec - NUM_THREADS'(1));

    assign idx_part[0] = '0;
    for (genvar gi = 1; gi < NUM_THREADS; gi++) begin : g_enc
        assign idx_part[gi] = idx_part[gi-1] | (grant_oh[gi] ? PTR_W'(gi) : '0);
    end
    assign grant_idx = idx_part[NUM_THREADS-1];

    assign ptr_next  = (grant_idx == PTR_W'(NUM_THREADS - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign grant_any = (|free_vec) && (remaining_reg != '0);
    assign chunk_len = (remaining_reg > CHUNK_L) ? CHUNK_L : remaining_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            busy_mask_reg <= '0;
            ptr_reg       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            thr_start     <= '0;
            thr_addr      <= '0;
            thr_len       <= '0;
        end else begin
            thr_start     <= '0;
            thr_addr      <= '0;
            thr_len       <= '0;
            done          <= 1'b0;
            // Completions are honoured in every state; a grant below re-sets only a thread that was free.
            busy_mask_reg <= busy_mask_reg & ~thr_done;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cur_addr_reg  <= base_addr;
                        remaining_reg <= total_len;
                        busy          <= 1'b1;
                        if (total_len == '0) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= S_DISPATCH;
                        end
                    end
                end
                S_DISPATCH: begin
                    if (grant_any) begin
                        thr_start     <= grant_oh;
                        thr_addr      <= cur_addr_reg;
                        thr_len       <= chunk_len;
                        cur_addr_reg  <= cur_addr_reg + ADDR_W'(chunk_len);
                        remaining_reg <= remaining_reg - chunk_len;
                        busy_mask_reg <= (busy_mask_reg & ~thr_done) | grant_oh;
                        ptr_reg       <= ptr_next;
                        if (remaining_reg == chunk_len) begin
                            state_reg <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (busy_mask_reg == '0) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPLIT_SCHED_PERF_CNT_EN
    logic [31:0] perf_cnt_reg;
    logic [31:0] perf_inc;

    assign perf_inc = (perf_cnt_reg == 32'hFFFF_FFFF) ? perf_cnt_reg : perf_cnt_reg + 32'd1;

    // The DONE cycle itself is counted, so the published value includes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt_reg <= '0;
            cycle_count  <= '0;
        end else if (state_reg == S_IDLE) begin
            if (start) begin
                perf_cnt_reg <= '0;
            end
        end else begin
            perf_cnt_reg <= perf_inc;
            if (state_reg == S_DONE) begin
                cycle_count <= perf_inc;
            end
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_split_thread_scheduler.sv
// Bench for split_thread_scheduler: directed scenarios then random jobs, checked cycle by cycle
// against a chunk-queue / busy-set reference model driven by reactive worker models.
module tb_split_thread_scheduler;
    localparam int NT = 4;
    localparam int CH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [15:0]   total_len = '0;
    logic          busy;
    logic          done;
    logic [NT-1:0] thr_start;
    logic [31:0]   thr_addr;
    logic [15:0]   thr_len;
    logic [NT-1:0] thr_done = '0;
    logic [31:0]   cycle_count;

    always #5 clk = ~clk;

    split_thread_scheduler #(
        .NUM_THREADS(NT),
        .ADDR_W(32),
        .LEN_W(16),
        .CHUNK(CH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .total_len(total_len),
        .busy(busy),
        .done(done),
        .thr_start(thr_start),
        .thr_addr(thr_addr),
        .thr_len(thr_len),
        .thr_done(thr_done),
        .cycle_count(cycle_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
    } chunk_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state (as the DUT should look after the latest rising edge)
    chunk_t        chunk_q[$];
    bit            m_active = 0;
    bit            m_done_prev = 0;
    logic [NT-1:0] m_mask = '0;
    int            m_ptr = 0;
    int            m_last_grant = 0;
    int            job_cycles = 0;
    logic [31:0]   exp_cc = '0;
    bit            job_done_evt = 0;

    // what was on the input pins during the cycle ending at the next edge
    bit            in_start = 0;
    logic [31:0]   in_base = '0;
    logic [15:0]   in_len = '0;
    logic [NT-1:0] in_done = '0;

    // stimulus requests for the next driven cycle
    bit            req_start = 0;
    logic [31:0]   req_base = '0;
    logic [15:0]   req_len = '0;
    logic [NT-1:0] req_stray = '0;
    bit            rand_mode = 0;

    int wrk_cnt[NT];
    int lat_fixed[NT];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic split_region(input logic [31:0] b, input logic [15:0] l);
        logic [31:0] a;
        int          r;
        int          n;
        a = b;
        r = int'(l);
        chunk_q.delete();
        while (r > 0) begin
            n = (r > CH) ? CH : r;
            chunk_q.push_back('{a, 16'(n)});
            a = a + 32'(n);
            r = r - n;
        end
    endtask

    task automatic model_edge(output logic [NT-1:0] e_start, output logic [31:0] e_addr,
                              output logic [15:0] e_len, output bit e_done);
        logic [NT-1:0] prev;
        logic [NT-1:0] bitv;
        chunk_t        c;
        int            g;
        int            t;
        prev    = m_mask;
        e_start = '0;
        e_addr  = '0;
        e_len   = '0;
        e_done  = 0;
        g       = -1;
        m_mask  = m_mask & ~in_done;
        if (m_active && m_done_prev) begin
            m_active = 0;
            exp_cc   = 32'(job_cycles);
        end else if (!m_active) begin
            if (in_start) begin
                m_active     = 1;
                job_cycles   = 0;
                m_last_grant = cyc;
                split_region(in_base, in_len);
                if (in_len == 16'd0) e_done = 1;
            end
        end else if (chunk_q.size() > 0) begin
            for (int k = 0; k < NT; k++) begin
                t    = (m_ptr + k) % NT;
                bitv = NT'(1) << t;
                if (g < 0 && (prev & bitv) == '0) g = t;
            end
            if (g >= 0) begin
                c            = chunk_q.pop_front();
                e_start      = NT'(1) << g;
                e_addr       = c.addr;
                e_len        = c.len;
                m_mask       = m_mask | e_start;
                m_ptr        = (g + 1) % NT;
                m_last_grant = cyc;
            end
        end else if (prev == '0 && cyc > m_last_grant) begin
            e_done = 1;
        end
        m_done_prev = e_done;
        if (m_active) job_cycles++;
        if (e_done) job_done_evt = 1;
    endtask

    // One clock: model the edge just taken, compare, run workers, drive inputs for the next edge.
    task automatic cycle();
        logic [NT-1:0] e_start;
        logic [31:0]   e_addr;
        logic [15:0]   e_len;
        bit            e_done;
        logic [NT-1:0] dn;
        @(negedge clk);
        cyc++;
        model_edge(e_start, e_addr, e_len, e_done);
        chk("thr_start", 64'(thr_start), 64'(e_start));
        chk("thr_addr", 64'(thr_addr), 64'(e_addr));
        chk("thr_len", 64'(thr_len), 64'(e_len));
        chk("done", 64'(done), 64'(e_done));
        chk("busy", 64'(busy), 64'(m_active));
`ifdef SPLIT_SCHED_PERF_CNT_EN
        chk("cycle_count", 64'(cycle_count), 64'(exp_cc));
`else
        chk("cycle_count", 64'(cycle_count), 64'd0);
`endif
        dn = '0;
        for (int i = 0; i < NT; i++) begin
            if (wrk_cnt[i] > 0) begin
                wrk_cnt[i]--;
                if (wrk_cnt[i] == 0) dn[i] = 1'b1;
            end
            if (thr_start[i]) wrk_cnt[i] = (lat_fixed[i] > 0) ? lat_fixed[i] : int'($urandom_range(1, 15));
        end
        if (rand_mode) begin
            if ($urandom_range(0, 4) == 0) req_stray = NT'($urandom);
            if (m_active && !req_start && $urandom_range(0, 7) == 0) begin
                req_start = 1;
                req_base  = $urandom;
                req_len   = 16'($urandom_range(0, 400));
            end
        end
        for (int i = 0; i < NT; i++) begin
            if (wrk_cnt[i] == 0 && req_stray[i]) dn[i] = 1'b1;
        end
        start     = req_start;
        base_addr = req_base;
        total_len = req_len;
        thr_done  = dn;
        in_start  = req_start;
        in_base   = req_base;
        in_len    = req_len;
        in_done   = dn;
        req_start = 0;
        req_stray = '0;
    endtask

    task automatic run_job(input logic [31:0] b, input logic [15:0] l,
                           input int ign_start_at, input int stray_at, input int stray_bit);
        bit fin;
        fin          = 0;
        job_done_evt = 0;
        req_start    = 1;
        req_base     = b;
        req_len      = l;
        cycle();
        for (int i = 0; i < 3000 && !fin; i++) begin
            if (i == ign_start_at) begin
                req_start = 1;
                req_base  = 32'hDEAD_0000;
                req_len   = 16'd512;
            end
            if (i == stray_at) req_stray[stray_bit] = 1'b1;
            cycle();
            if (job_done_evt) fin = 1;
        end
        chk("job_completes", 64'(fin), 64'd1);
        cycle();
        cycle();
    endtask

    task automatic model_reset();
        chunk_q.delete();
        m_active    = 0;
        m_done_prev = 0;
        m_mask      = '0;
        m_ptr       = 0;
        exp_cc      = '0;
        in_start    = 0;
        in_done     = '0;
        req_start   = 0;
        req_stray   = '0;
        for (int i = 0; i < NT; i++) wrk_cnt[i] = 0;
        start    = 1'b0;
        thr_done = '0;
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat_fixed[0] = l0;
        lat_fixed[1] = l1;
        lat_fixed[2] = l2;
        lat_fixed[3] = l3;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_thr_start"}, 64'(thr_start), 64'd0);
        chk({tag, "_thr_addr"}, 64'(thr_addr), 64'd0);
        chk({tag, "_thr_len"}, 64'(thr_len), 64'd0);
        chk({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
    endtask

    initial begin
        logic [15:0] rl;
        model_reset();
        set_lat(10, 10, 10, 10);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        run_job(32'h0000_1000, 16'd256, -1, -1, 0);   // four full chunks
        run_job(32'h0000_2000, 16'd300, -1, -1, 0);   // fifth short chunk waits for thread 0
        run_job(32'h0000_3000, 16'd0, -1, -1, 0);     // empty job
        run_job(32'h0000_1000, 16'd256, 2, 0, 2);     // ignored start and stray completion
        set_lat(3, 10, 4, 8);
        run_job(32'h0000_5000, 16'd256, -1, -1, 0);   // threads 1 and 3 finish together
        set_lat(10, 10, 10, 10);
        run_job(32'hFFFF_FFC0, 16'd200, -1, -1, 0);   // address wraps

        // abort mid-dispatch, then rerun the basic job
        req_start = 1;
        req_base  = 32'h0000_2000;
        req_len   = 16'd300;
        cycle();
        repeat (4) cycle();
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("abort_hold");
        reset = 1'b0;
        run_job(32'h0000_1000, 16'd256, -1, -1, 0);

        rand_mode = 1;
        set_lat(0, 0, 0, 0);
        for (int j = 0; j < 25; j++) begin
            case ($urandom_range(0, 4))
                0:       rl = 16'd0;
                1:       rl = 16'($urandom_range(1, 63));
                2:       rl = 16'(64 * $urandom_range(1, 8));
                default: rl = 16'($urandom_range(1, 700));
            endcase
            run_job($urandom, rl, -1, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
